// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : op encodings, FSM states, lane constants, op classifiers
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Logical lane numbers as seen in the byte address.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       LANE_H0 = 1'b0;
  localparam logic       LANE_H1 = 1'b1;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_half(input mem_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : load lane extract/extend and store lane merge (combinational)
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter bit BYTE_LE = 1'b1
) (
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);

  logic [1:0]  bpos;
  logic        hpos;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Physical lane position inside the word after applying byte order.
  assign bpos = BYTE_LE ? addr_lo : (LANE_B3 - addr_lo);
  assign hpos = BYTE_LE ? addr_lo[1] : (LANE_H1 ^ addr_lo[1]);

  assign byte_sel = rdata[{bpos, 3'b000} +: 8];
  assign half_sel = rdata[{hpos, 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      OP_LW:   load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (op)
      OP_SB:   merged[{bpos, 3'b000} +: 8]  = new_data[7:0];
      OP_SH:   merged[{hpos, 4'b0000} +: 16] = new_data[15:0];
      OP_SW:   merged = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage byte/half/word access controller with RMW stores
// Optional macro MEM_ALIGN_TRAP_EN enables misalignment trapping.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter bit BYTE_LE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              misalign,
  output logic [31:0]       bad_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen,
  input  logic [31:0]       ram_rdata
);

  state_e      state, state_nxt;
  mem_op_e     op;
  logic [1:0]  eff_lo;
  logic        misaligned;
  logic        sub_store;
  logic        ld_fire;
  logic        buf_load;
  logic        wen_raw;
  logic        stall_raw;
  logic [31:0] merge_buf;
  logic [31:0] load_word;
  logic [31:0] merged_word;
  logic        unused_addr_hi;

  assign op        = mem_op_e'(req_op);
  assign sub_store = (op == OP_SB) || (op == OP_SH);
  assign ram_addr  = req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_TRAP_EN
  assign eff_lo     = req_addr[1:0];
  assign misaligned = req_valid &&
                      ((is_word(op) && (req_addr[1:0] != 2'b00)) ||
                       (is_half(op) && req_addr[0]));
`else
  // Without trapping, the access is forced onto its natural boundary.
  assign eff_lo     = is_word(op) ? 2'b00 :
                      is_half(op) ? {req_addr[1], 1'b0} : req_addr[1:0];
  assign misaligned = 1'b0;
`endif

  mem_lane_align #(
    .BYTE_LE (BYTE_LE)
  ) u_lane_align (
    .op        (op),
    .addr_lo   (eff_lo),
    .rdata     (ram_rdata),
    .load_data (load_word),
    .old_word  (merge_buf),
    .new_data  (req_wdata),
    .merged    (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    wen_raw   = 1'b0;
    ram_wdata = req_wdata;
    buf_load  = 1'b0;
    ld_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !misaligned) begin
          if (is_load(op)) begin
            ld_fire = 1'b1;
          end else if (op == OP_SW) begin
            wen_raw = 1'b1;
          end else if (sub_store) begin
            stall_raw = 1'b1;
            buf_load  = 1'b1;
            state_nxt = MERGE;
          end
        end
      end
      MERGE: begin
        wen_raw   = 1'b1;
        ram_wdata = merged_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must suppress the RAM write and stall even while a request is held.
  assign ram_wen = wen_raw & ~rst;
  assign stall   = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid  <= 1'b0;
      ld_data   <= 32'd0;
      merge_buf <= 32'd0;
    end else begin
      ld_valid <= ld_fire;
      if (ld_fire) begin
        ld_data <= load_word;
      end
      if (buf_load) begin
        merge_buf <= ram_rdata;
      end
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
      bad_addr <= 32'd0;
    end else begin
      misalign <= misaligned;
      if (misaligned) begin
        bad_addr <= req_addr;
      end
    end
  end
`else
  assign misalign = 1'b0;
  assign bad_addr = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : directed vector table plus RMW / reset corner sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              misalign;
  logic [31:0]       bad_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_wen;
  logic [31:0]       ram_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .BYTE_LE (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .misalign  (misalign),
    .bad_addr  (bad_addr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(negedge clk) if (ram_wen) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic        exp_ldv;
    logic [31:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] bad_model = 32'd0;
  logic [31:0] ref_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic st, input logic wen,
                              input logic [31:0] ewd, input logic ldv, input logic [31:0] eld,
                              input logic mis);
    vec_t r;
    r.valid = v; r.op = op; r.addr = a; r.wdata = wd;
    r.exp_stall = st; r.exp_wen = wen; r.exp_wdata = ewd;
    r.exp_ldv = ldv; r.exp_ld = eld; r.exp_mis = mis;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; req_op = op; req_addr = a; req_wdata = wd;
  endtask

  // Caller sits 1 time unit after a rising edge.
  task automatic sub_store(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_word);
    drive(1'b1, op, a, wd);
    #2;
    chk("rmw_c0_stall", stall, 1);
    chk("rmw_c0_wen", ram_wen, 0);
    @(posedge clk); #1;
    chk("rmw_c1_stall", stall, 0);
    chk("rmw_c1_wen", ram_wen, 1);
    chk("rmw_c1_wdata", ram_wdata, exp_word);
    chk("rmw_c1_ldv", ld_valid, 0);
    @(posedge clk); #1;
    n_vec++;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, op, a, 32'd0);
    #2;
    chk("load_stall", stall, 0);
    chk("load_wen", ram_wen, 0);
    @(posedge clk); #1;
    chk("load_ldv", ld_valid, 1);
    chk("load_data", ld_data, exp);
    n_vec++;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    mem[4]  = 32'h8899AABB;
    mem[12] = 32'h55667788;

    // Reset: a held SW must not write while rst is high.
    rst = 1'b1;
    drive(1'b1, OP_SW, 32'h20, 32'hDEADBEEF);
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_ldv", ld_valid, 0);
    chk("rst_lddata", ld_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_badaddr", bad_addr, 0);
    n_vec++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, OP_LB, 32'h0, 32'h0);

    vecs.push_back(mk(1, OP_LB,  32'h10, 0, 0, 0, 0, 1, 32'hFFFFFFBB, 0));
    vecs.push_back(mk(1, OP_LBU, 32'h11, 0, 0, 0, 0, 1, 32'h000000AA, 0));
    vecs.push_back(mk(1, OP_LH,  32'h12, 0, 0, 0, 0, 1, 32'hFFFF8899, 0));
    vecs.push_back(mk(1, OP_LHU, 32'h12, 0, 0, 0, 0, 1, 32'h00008899, 0));
    vecs.push_back(mk(1, OP_LBU, 32'h13, 0, 0, 0, 0, 1, 32'h00000088, 0));
    vecs.push_back(mk(1, OP_LB,  32'h12, 0, 0, 0, 0, 1, 32'hFFFFFF99, 0));
    vecs.push_back(mk(1, OP_LH,  32'h10, 0, 0, 0, 0, 1, 32'hFFFFAABB, 0));
    vecs.push_back(mk(1, OP_LW,  32'h10, 0, 0, 0, 0, 1, 32'h8899AABB, 0));
    vecs.push_back(mk(1, OP_SW,  32'h20, 32'h12345678, 0, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  32'h20, 0, 0, 0, 0, 1, 32'h12345678, 0));
    vecs.push_back(mk(0, OP_SW,  32'h24, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_LW,  32'h00040010, 0, 0, 0, 0, 1, 32'h8899AABB, 0));
`ifdef MEM_ALIGN_TRAP_EN
    vecs.push_back(mk(1, OP_LW,  32'h22, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, OP_SW,  32'h41, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, OP_LH,  32'h11, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, OP_LB,  32'h11, 0, 0, 0, 0, 1, 32'hFFFFFFAA, 0));
`else
    vecs.push_back(mk(1, OP_LW,  32'h22, 0, 0, 0, 0, 1, 32'h12345678, 0));
    vecs.push_back(mk(1, OP_SW,  32'h41, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 0, 0, 0));
    vecs.push_back(mk(1, OP_LH,  32'h11, 0, 0, 0, 0, 1, 32'hFFFFAABB, 0));
    vecs.push_back(mk(1, OP_LHU, 32'h13, 0, 0, 0, 0, 1, 32'h00008899, 0));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].wdata);
      #2;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("v%0d_wen", i), ram_wen, vecs[i].exp_wen);
      if (vecs[i].exp_wen) chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ldv", i), ld_valid, vecs[i].exp_ldv);
      if (vecs[i].exp_ldv) chk($sformatf("v%0d_lddata", i), ld_data, vecs[i].exp_ld);
      chk($sformatf("v%0d_misalign", i), misalign, vecs[i].exp_mis);
      if (vecs[i].exp_mis) bad_model = vecs[i].addr;
      chk($sformatf("v%0d_badaddr", i), bad_addr, bad_model);
      n_vec++;
    end

    // SB into word 8, then read back the merged word.
    sub_store(OP_SB, 32'h21, 32'h000000EE, 32'h1234EE78);
    do_load(OP_LW, 32'h20, 32'h1234EE78);

    // Reset in the MERGE cycle abandons the pending write.
    drive(1'b1, OP_SH, 32'h30, 32'h0000BEEF);
    #2;
    chk("shrst_c0_stall", stall, 1);
    @(posedge clk); #1;
    chk("shrst_c1_wen", ram_wen, 1);
    chk("shrst_c1_wdata", ram_wdata, 32'h5566BEEF);
    #1;
    rst = 1'b1;
    #1;
    chk("shrst_wen", ram_wen, 0);
    chk("shrst_stall", stall, 0);
    chk("shrst_ldv", ld_valid, 0);
    chk("shrst_lddata", ld_data, 0);
    chk("shrst_misalign", misalign, 0);
    chk("shrst_badaddr", bad_addr, 0);
    bad_model = 32'd0;
    n_vec++;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_load(OP_LW, 32'h30, 32'h55667788);

    // Alternating SB/LB on word 12 against a reference word.
    ref_word = 32'h55667788;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      case (i)
        0:       d = 8'hA5;
        1:       d = 8'h3C;
        2:       d = 8'h81;
        default: d = 8'h7F;
      endcase
      ref_word[8*i +: 8] = d;
      sub_store(OP_SB, 32'h30 + i, {24'hFFFFFF, d}, ref_word);
      do_load(OP_LB, 32'h30 + i, {{24{d[7]}}, d});
    end
    ref_word[31:16] = 16'hBEEF;
    sub_store(OP_SH, 32'h32, 32'h1234BEEF, ref_word);
    do_load(OP_LHU, 32'h32, 32'h0000BEEF);
    do_load(OP_LW, 32'h30, ref_word);
    drive(1'b0, OP_LB, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("idle_ldv_drop", ld_valid, 0);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
